// File: rtl/topo2a_ad_dense_acc.sv
// Dense-layer neuron accumulator: sums N_TERMS signed product terms onto a bias
// with saturation, then applies ReLU, an arithmetic right shift and an output clamp.
module topo2a_ad_dense_acc #(
  parameter int PROD_WIDTH = 26,
  parameter int ACC_WIDTH  = 32,
  parameter int N_TERMS    = 16,
  parameter int SHIFT      = 10,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic                  in_neg,
  input  logic [ACC_WIDTH-1:0]  bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] ACC_ONE  = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [7:0]           CNT_LAST = 8'(N_TERMS - 1);

  // Returns {saturated, sum} for a signed add clamped to the accumulator range.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] wide;
    wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
      sat_add = {1'b1, (wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
    end else begin
      sat_add = {1'b0, wide[ACC_WIDTH-1:0]};
    end
  endfunction

  // ReLU, shift and clamp of a finished accumulator value.
  function automatic logic [OUT_WIDTH-1:0] scale(input logic [ACC_WIDTH-1:0] a);
    logic [ACC_WIDTH-1:0] sh;
    if (a[ACC_WIDTH-1]) begin
      sh = {ACC_WIDTH{1'b0}};
    end else begin
      sh = a >> SHIFT;
    end
    if (|sh[ACC_WIDTH-1:OUT_WIDTH]) begin
      scale = {OUT_WIDTH{1'b1}};
    end else begin
      scale = sh[OUT_WIDTH-1:0];
    end
  endfunction

  state_t                 state_r;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic [7:0]             cnt_r;
  logic [OUT_WIDTH-1:0]   out_data_r;
  logic                   out_valid_r;
  logic                   in_ready_r;
  logic                   ovf_r;

  logic [ACC_WIDTH-1:0]   mag_s;
  logic [ACC_WIDTH-1:0]   term_s;
  logic [ACC_WIDTH-1:0]   addend_s;
  logic [ACC_WIDTH:0]     add_s;
  logic                   accept_s;
  logic                   last_s;

  // Term formation, adder operand selection and last-term detection.
  always_comb begin
    mag_s    = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, in_prod};
    term_s   = mag_s;
    addend_s = acc_r;
    last_s   = 1'b0;
    if (in_neg) begin
      term_s = ~mag_s + ACC_ONE;
    end else begin
      term_s = mag_s;
    end
    if (state_r == IDLE) begin
      addend_s = bias;
      last_s   = (N_TERMS == 1);
    end else begin
      addend_s = acc_r;
      last_s   = (cnt_r == CNT_LAST);
    end
    add_s    = sat_add(addend_s, term_s);
    accept_s = in_valid & in_ready_r;
  end

  // Neuron sequencing, accumulation and registered result/handshake outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_WIDTH{1'b0}};
      cnt_r       <= 8'd0;
      out_data_r  <= {OUT_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACC: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            acc_r <= add_s[ACC_WIDTH-1:0];
            cnt_r <= (state_r == IDLE) ? 8'd1 : cnt_r + 8'd1;
            ovf_r <= ovf_r | add_s[ACC_WIDTH];
            if (last_s) begin
              state_r     <= HOLD;
              out_data_r  <= scale(add_s[ACC_WIDTH-1:0]);
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              state_r <= ACC;
            end
          end else begin
            state_r <= state_r;
          end
        end
        HOLD: begin
          if (out_valid_r && out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign ovf       = ovf_r;

endmodule
